// File: rtl/metronome_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : metronome_ctrl
//  Description : Tempo and measure controller for the metronome beat
//                generator. Turns up/down keys (with auto-repeat) into a
//                saturating BPM setting and derives the beat period with a
//                serial restoring divider. It then times the beats, tracks
//                the position in the measure and drives the BEEP/ACCENT
//                pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module metronome_ctrl #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned BPM_MIN     = 40,
    parameter int unsigned BPM_MAX     = 240,
    parameter int unsigned BPM_INIT    = 120,
    parameter int unsigned REPEAT_DLY  = 25_000_000,
    parameter int unsigned REPEAT_RATE = 5_000_000,
    parameter int unsigned PULSE_LEN   = 1_000_000,
    parameter int unsigned ACCENT_LEN  = 2_000_000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       KEY_UP,
    input  logic       KEY_DN,
    input  logic       RUN,
    input  logic [2:0] BEATS,
    output logic [7:0] BPM,
    output logic [2:0] BEAT_POS,
    output logic       BEEP,
    output logic       ACCENT,
    output logic       BUSY
);

    // Numerator of the period computation: clock cycles per minute.
    localparam logic [31:0] DIVIDEND    = 32'(64'(CLK_HZ) * 64'd60);
    localparam logic [31:0] PERIOD_INIT = DIVIDEND / 32'(BPM_INIT);
    localparam logic [7:0]  BPM_MIN_V   = 8'(BPM_MIN);
    localparam logic [7:0]  BPM_MAX_V   = 8'(BPM_MAX);
    localparam logic [7:0]  BPM_INIT_V  = 8'(BPM_INIT);
    localparam logic [31:0] DLY_V       = 32'(REPEAT_DLY);
    localparam logic [31:0] RATE_V      = 32'(REPEAT_RATE);
    // Pulse counters are loaded with "remaining cycles after this one".
    localparam logic [31:0] PULSE_LAST  = 32'(PULSE_LEN - 1);
    localparam logic [31:0] ACCENT_LAST = 32'(ACCENT_LEN - 1);

    // ------------------------------------------------------------------
    // Key handling
    // ------------------------------------------------------------------
    logic        up_q;
    logic        dn_q;
    logic        up_armed;
    logic        dn_armed;
    logic        up_rep;
    logic        dn_rep;
    logic [31:0] up_cnt;
    logic [31:0] dn_cnt;
    logic        up_step;
    logic        dn_step;

    // A step is due on a fresh press, after the hold delay, or on each repeat tick.
    always_comb begin
        up_step = 1'b0;
        dn_step = 1'b0;
        if (KEY_UP && !KEY_DN) begin
            if (!up_q) begin
                up_step = 1'b1;
            end else if (up_armed) begin
                if (!up_rep && (up_cnt + 32'd1 == DLY_V)) begin
                    up_step = 1'b1;
                end else if (up_rep && (up_cnt + 32'd1 == RATE_V)) begin
                    up_step = 1'b1;
                end
            end
        end
        if (KEY_DN && !KEY_UP) begin
            if (!dn_q) begin
                dn_step = 1'b1;
            end else if (dn_armed) begin
                if (!dn_rep && (dn_cnt + 32'd1 == DLY_V)) begin
                    dn_step = 1'b1;
                end else if (dn_rep && (dn_cnt + 32'd1 == RATE_V)) begin
                    dn_step = 1'b1;
                end
            end
        end
    end

    // Edge detection and hold/repeat timers; pressing both keys disarms both.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
            up_armed <= 1'b0;
            dn_armed <= 1'b0;
            up_rep   <= 1'b0;
            dn_rep   <= 1'b0;
            up_cnt   <= 32'd0;
            dn_cnt   <= 32'd0;
        end else begin
            up_q <= KEY_UP;
            dn_q <= KEY_DN;
            if (KEY_UP && KEY_DN) begin
                up_armed <= 1'b0;
                dn_armed <= 1'b0;
                up_rep   <= 1'b0;
                dn_rep   <= 1'b0;
                up_cnt   <= 32'd0;
                dn_cnt   <= 32'd0;
            end else begin
                if (!KEY_UP) begin
                    up_armed <= 1'b0;
                    up_rep   <= 1'b0;
                    up_cnt   <= 32'd0;
                end else if (!up_q) begin
                    up_armed <= 1'b1;
                    up_rep   <= 1'b0;
                    up_cnt   <= 32'd0;
                end else if (up_armed) begin
                    if (up_step) begin
                        up_rep <= 1'b1;
                        up_cnt <= 32'd0;
                    end else begin
                        up_cnt <= up_cnt + 32'd1;
                    end
                end

                if (!KEY_DN) begin
                    dn_armed <= 1'b0;
                    dn_rep   <= 1'b0;
                    dn_cnt   <= 32'd0;
                end else if (!dn_q) begin
                    dn_armed <= 1'b1;
                    dn_rep   <= 1'b0;
                    dn_cnt   <= 32'd0;
                end else if (dn_armed) begin
                    if (dn_step) begin
                        dn_rep <= 1'b1;
                        dn_cnt <= 32'd0;
                    end else begin
                        dn_cnt <= dn_cnt + 32'd1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Tempo register and serial divider
    // ------------------------------------------------------------------
    logic [7:0]  bpm_next;
    logic        bpm_change;
    logic        div_load;
    logic [4:0]  div_cnt;
    logic [31:0] div_rem;
    logic [31:0] div_quo;
    logic [7:0]  div_dvs;
    logic [31:0] period;
    logic [32:0] rem_shift;
    logic        rem_fits;
    logic [31:0] rem_new;
    logic [31:0] quo_new;

    // Saturating tempo step; a step clipped by saturation is not a change.
    always_comb begin
        bpm_next   = BPM;
        bpm_change = 1'b0;
        if (up_step && (BPM < BPM_MAX_V)) begin
            bpm_next   = BPM + 8'd1;
            bpm_change = 1'b1;
        end else if (dn_step && (BPM > BPM_MIN_V)) begin
            bpm_next   = BPM - 8'd1;
            bpm_change = 1'b1;
        end
    end

    // One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift = {div_rem, div_quo[31]};
        rem_fits  = (rem_shift >= {25'd0, div_dvs});
        rem_new   = rem_fits ? 32'(rem_shift - {25'd0, div_dvs}) : rem_shift[31:0];
        quo_new   = {div_quo[30:0], rem_fits};
    end

    // Tempo register plus divider sequencing: a load cycle, then 32 iterations.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            BPM      <= BPM_INIT_V;
            BUSY     <= 1'b0;
            div_load <= 1'b0;
            div_cnt  <= 5'd0;
            div_rem  <= 32'd0;
            div_quo  <= 32'd0;
            div_dvs  <= 8'd0;
            period   <= PERIOD_INIT;
        end else begin
            BPM <= bpm_next;
            if (bpm_change) begin
                // A new tempo (re)starts the divide; the old period stays in use.
                BUSY     <= 1'b1;
                div_load <= 1'b1;
            end else if (BUSY) begin
                if (div_load) begin
                    div_load <= 1'b0;
                    div_rem  <= 32'd0;
                    div_quo  <= DIVIDEND;
                    div_dvs  <= BPM;
                    div_cnt  <= 5'd0;
                end else begin
                    div_rem <= rem_new;
                    div_quo <= quo_new;
                    div_cnt <= div_cnt + 5'd1;
                    if (div_cnt == 5'd31) begin
                        BUSY   <= 1'b0;
                        period <= quo_new;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Beat state machine
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } beat_state_t;

    beat_state_t state;
    logic [31:0] beat_cnt;
    logic [31:0] pulse_rem;
    logic [2:0]  beats_eff;
    logic [2:0]  pos_adv;
    logic        beat_due;
    logic [2:0]  fire_pos;
    logic [31:0] fire_len;

    // Next measure position and the pulse length of the beat about to fire.
    always_comb begin
        beats_eff = (BEATS == 3'd0) ? 3'd1 : BEATS;
        pos_adv   = (BEAT_POS >= beats_eff - 3'd1) ? 3'd0 : BEAT_POS + 3'd1;
        // ">=" so that a shortened period fires at once if already overrun.
        beat_due  = (beat_cnt >= period - 32'd1);
        fire_pos  = (state == ST_IDLE) ? 3'd0 : pos_adv;
        fire_len  = (fire_pos == 3'd0) ? ACCENT_LAST : PULSE_LAST;
    end

    // Beat timing, measure position and registered BEEP/ACCENT pulses.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state     <= ST_IDLE;
            beat_cnt  <= 32'd0;
            pulse_rem <= 32'd0;
            BEAT_POS  <= 3'd0;
            BEEP      <= 1'b0;
            ACCENT    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (RUN) begin
                        state     <= ST_RUN;
                        beat_cnt  <= 32'd0;
                        BEAT_POS  <= fire_pos;
                        BEEP      <= 1'b1;
                        ACCENT    <= (fire_pos == 3'd0);
                        pulse_rem <= fire_len;
                    end
                end
                ST_RUN: begin
                    if (!RUN) begin
                        // Stopping resets the measure so a restart is a downbeat.
                        state     <= ST_IDLE;
                        beat_cnt  <= 32'd0;
                        pulse_rem <= 32'd0;
                        BEAT_POS  <= 3'd0;
                        BEEP      <= 1'b0;
                        ACCENT    <= 1'b0;
                    end else if (beat_due) begin
                        beat_cnt  <= 32'd0;
                        BEAT_POS  <= fire_pos;
                        BEEP      <= 1'b1;
                        ACCENT    <= (fire_pos == 3'd0);
                        pulse_rem <= fire_len;
                    end else begin
                        beat_cnt <= beat_cnt + 32'd1;
                        if (BEEP) begin
                            if (pulse_rem == 32'd0) begin
                                BEEP   <= 1'b0;
                                ACCENT <= 1'b0;
                            end else begin
                                pulse_rem <= pulse_rem - 32'd1;
                            end
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_metronome_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_metronome_ctrl
//  Description : Scoreboard bench for metronome_ctrl. A behavioural model
//                predicts tempo, BUSY, beat and pulse-end events; a monitor
//                pops and compares them as the design produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_metronome_ctrl;

    localparam int CLK_HZ      = 1200;
    localparam int BPM_MIN     = 40;
    localparam int BPM_MAX     = 240;
    localparam int BPM_INIT    = 120;
    localparam int REPEAT_DLY  = 100;
    localparam int REPEAT_RATE = 20;
    localparam int PULSE_LEN   = 10;
    localparam int ACCENT_LEN  = 20;
    localparam int CYC_PER_MIN = CLK_HZ * 60;
    localparam int DIV_CYCLES  = 33;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_up;
    logic       key_dn;
    logic       run;
    logic [2:0] beats;
    logic [7:0] bpm;
    logic [2:0] beat_pos;
    logic       beep;
    logic       accent;
    logic       busy;

    always #5 clk = ~clk;

    metronome_ctrl #(
        .CLK_HZ      (CLK_HZ),
        .BPM_MIN     (BPM_MIN),
        .BPM_MAX     (BPM_MAX),
        .BPM_INIT    (BPM_INIT),
        .REPEAT_DLY  (REPEAT_DLY),
        .REPEAT_RATE (REPEAT_RATE),
        .PULSE_LEN   (PULSE_LEN),
        .ACCENT_LEN  (ACCENT_LEN)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .KEY_UP   (key_up),
        .KEY_DN   (key_dn),
        .RUN      (run),
        .BEATS    (beats),
        .BPM      (bpm),
        .BEAT_POS (beat_pos),
        .BEEP     (beep),
        .ACCENT   (accent),
        .BUSY     (busy)
    );

    typedef struct { int t; int v; } ev_t;
    typedef struct { int t; int pos; int acc; } beat_t;

    ev_t   bpm_q[$];
    ev_t   busy_q[$];
    ev_t   fall_q[$];
    beat_t beat_q[$];

    int checks   = 0;
    int failures = 0;
    bit tracking = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: tempo rules, elapsed-time beat scheduling
    // ------------------------------------------------------------------
    int m_n = 0;
    int m_bpm, m_period, m_pend, m_done;
    bit m_busy;
    bit m_pu, m_pd, up_arm, dn_arm;
    int up_e, dn_e;
    bit m_run, m_beep;
    int m_last, m_pos, m_off;

    function automatic bit repeat_hit(input int k);
        return (k == REPEAT_DLY) ||
               ((k > REPEAT_DLY) && (((k - REPEAT_DLY) % REPEAT_RATE) == 0));
    endfunction

    task automatic model_init();
        m_bpm = BPM_INIT; m_period = CYC_PER_MIN / BPM_INIT; m_busy = 1'b0;
        m_pend = BPM_INIT; m_done = 0;
        m_pu = 1'b0; m_pd = 1'b0; up_arm = 1'b0; dn_arm = 1'b0; up_e = 0; dn_e = 0;
        m_run = 1'b0; m_beep = 1'b0; m_last = 0; m_pos = 0; m_off = 0;
    endtask

    task automatic model_fire(input int p);
        m_last = m_n;
        m_pos  = p;
        m_beep = 1'b1;
        m_off  = m_n + ((p == 0) ? ACCENT_LEN : PULSE_LEN);
        if (tracking) beat_q.push_back('{m_n, p, (p == 0) ? 1 : 0});
    endtask

    initial model_init();

    always @(posedge clk) begin
        bit ustep, dstep, chg;
        int beff;
        m_n++;
        if (rst) begin
            if (tracking) begin
                if (m_bpm != BPM_INIT) bpm_q.push_back('{m_n, BPM_INIT});
                if (m_busy) busy_q.push_back('{m_n, 0});
                if (m_beep) fall_q.push_back('{m_n, 0});
            end
            model_init();
        end else begin
            // Beats use the period in force before this clock edge.
            beff = (beats == 3'd0) ? 1 : int'(beats);
            if (!m_run) begin
                if (run) begin
                    m_run = 1'b1;
                    model_fire(0);
                end
            end else if (!run) begin
                m_run = 1'b0;
                m_pos = 0;
                if (m_beep) begin
                    m_beep = 1'b0;
                    if (tracking) fall_q.push_back('{m_n, 0});
                end
            end else if (m_n - m_last >= m_period) begin
                model_fire((m_pos >= beff - 1) ? 0 : m_pos + 1);
            end else if (m_beep && m_n >= m_off) begin
                m_beep = 1'b0;
                if (tracking) fall_q.push_back('{m_n, 0});
            end

            ustep = 1'b0;
            dstep = 1'b0;
            if (key_up && key_dn) begin
                up_arm = 1'b0;
                dn_arm = 1'b0;
            end else begin
                if (!key_up) up_arm = 1'b0;
                else if (!m_pu) begin ustep = 1'b1; up_arm = 1'b1; up_e = m_n; end
                else if (up_arm && repeat_hit(m_n - up_e)) ustep = 1'b1;
                if (!key_dn) dn_arm = 1'b0;
                else if (!m_pd) begin dstep = 1'b1; dn_arm = 1'b1; dn_e = m_n; end
                else if (dn_arm && repeat_hit(m_n - dn_e)) dstep = 1'b1;
            end
            m_pu = key_up;
            m_pd = key_dn;

            chg = 1'b0;
            if (ustep && m_bpm < BPM_MAX) begin m_bpm++; chg = 1'b1; end
            if (dstep && m_bpm > BPM_MIN) begin m_bpm--; chg = 1'b1; end
            if (chg) begin
                if (tracking) begin
                    bpm_q.push_back('{m_n, m_bpm});
                    if (!m_busy) busy_q.push_back('{m_n, 1});
                end
                m_busy = 1'b1;
                m_pend = m_bpm;
                m_done = m_n + DIV_CYCLES;
            end else if (m_busy && m_n == m_done) begin
                m_busy   = 1'b0;
                m_period = CYC_PER_MIN / m_pend;
                if (tracking) busy_q.push_back('{m_n, 0});
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: each observed output event pops the matching expectation
    // ------------------------------------------------------------------
    int mon_n = 0;
    int p_bpm = BPM_INIT;
    bit p_busy = 1'b0;
    bit p_beep = 1'b0;

    always @(negedge clk) begin
        ev_t   e;
        beat_t b;
        mon_n++;
        if (tracking) begin
            if (int'(bpm) != p_bpm) begin
                if (bpm_q.size() == 0) check("bpm_unexpected_change", int'(bpm), p_bpm);
                else begin
                    e = bpm_q.pop_front();
                    check("bpm_time", mon_n, e.t);
                    check("bpm_value", int'(bpm), e.v);
                end
            end
            if (busy != p_busy) begin
                if (busy_q.size() == 0) check("busy_unexpected_edge", int'(busy), int'(p_busy));
                else begin
                    e = busy_q.pop_front();
                    check("busy_time", mon_n, e.t);
                    check("busy_level", int'(busy), e.v);
                end
            end
            if (beep && !p_beep) begin
                if (beat_q.size() == 0) check("beat_unexpected", 1, 0);
                else begin
                    b = beat_q.pop_front();
                    check("beat_time", mon_n, b.t);
                    check("beat_pos", int'(beat_pos), b.pos);
                    check("beat_accent", int'(accent), b.acc);
                end
            end else if (!beep && p_beep) begin
                if (fall_q.size() == 0) check("beep_fall_unexpected", 1, 0);
                else begin
                    e = fall_q.pop_front();
                    check("beep_fall_time", mon_n, e.t);
                    check("accent_with_beep_low", int'(accent), 0);
                end
            end
            p_bpm  = int'(bpm);
            p_busy = busy;
            p_beep = beep;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int act;
        int i;
        rst = 1'b1; key_up = 1'b0; key_dn = 1'b0; run = 1'b0; beats = 3'd4;
        cycles(3);
        check("reset_bpm", int'(bpm), BPM_INIT);
        check("reset_busy", int'(busy), 0);
        check("reset_beep", int'(beep), 0);
        check("reset_accent", int'(accent), 0);
        check("reset_beat_pos", int'(beat_pos), 0);
        tracking = 1'b1;
        rst = 1'b0;

        // Start a 4-beat measure at the reset tempo.
        run = 1'b1; beats = 3'd4;
        cycles(2500);

        // Single up press: one step and one divide.
        key_up = 1'b1; cycles(3); key_up = 1'b0;
        cycles(1300);

        // Ramp down to 42, then hold down into saturation.
        key_dn = 1'b1;
        for (i = 0; i < 5000 && m_bpm != 42; i++) cycles(1);
        key_dn = 1'b0;
        check("ramp_down_reached", m_bpm, 42);
        cycles(50);
        key_dn = 1'b1; cycles(REPEAT_DLY + REPEAT_RATE * 5); key_dn = 1'b0;
        cycles(2000);

        // Both keys together: nothing changes.
        key_up = 1'b1; key_dn = 1'b1; cycles(300); key_up = 1'b0; key_dn = 1'b0;
        cycles(50);

        // Ramp to the top tempo; the stale long period is replaced mid-count.
        key_up = 1'b1;
        for (i = 0; i < 8000 && m_bpm != BPM_MAX; i++) cycles(1);
        cycles(60);
        key_up = 1'b0;
        check("ramp_up_reached", m_bpm, BPM_MAX);
        cycles(1000);

        // Stop mid-measure at position 2, restart 50 cycles later.
        for (i = 0; i < 5000 && !(m_pos == 2 && !m_beep); i++) cycles(1);
        check("pos2_reached", m_pos, 2);
        cycles(40);
        run = 1'b0; cycles(50); run = 1'b1;
        cycles(1000);

        // Reset while the divider is busy.
        key_dn = 1'b1; cycles(2); key_dn = 1'b0;
        cycles(10);
        rst = 1'b1; cycles(1); rst = 1'b0;
        cycles(700);

        // Randomised mix of key presses, run toggles and measure sizes.
        for (int it = 0; it < 40; it++) begin
            act = $urandom_range(0, 6);
            case (act)
                0: begin key_up = 1'b1; cycles($urandom_range(1, 30)); key_up = 1'b0; end
                1: begin key_dn = 1'b1; cycles($urandom_range(1, 30)); key_dn = 1'b0; end
                2: begin key_up = 1'b1; cycles($urandom_range(90, 220)); key_up = 1'b0; end
                3: begin key_dn = 1'b1; cycles($urandom_range(90, 220)); key_dn = 1'b0; end
                4: begin run = ~run; end
                5: begin beats = 3'($urandom_range(0, 7)); end
                default: begin
                    if ($urandom_range(0, 3) == 0) begin
                        rst = 1'b1; cycles(1); rst = 1'b0;
                    end else begin
                        key_up = 1'b1; cycles($urandom_range(1, 5)); key_dn = 1'b1;
                        cycles($urandom_range(10, 150));
                        key_up = 1'b0; key_dn = 1'b0;
                    end
                end
            endcase
            cycles($urandom_range(20, 400));
        end

        // Drain: stop, let the divide and pulses finish, then confirm nothing is pending.
        run = 1'b1; cycles(2000);
        run = 1'b0; cycles(100);
        check("pending_bpm_events", bpm_q.size(), 0);
        check("pending_busy_events", busy_q.size(), 0);
        check("pending_beats", beat_q.size(), 0);
        check("pending_beep_falls", fall_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
